// File: rtl/axistream_pkg.sv
// Shared helpers for the AXI-Stream width converters: counter sizing and
// mapping from arrival order to slot position.
package axistream_pkg;

    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

    // Position of the pos-th accepted word inside the wide word.
    function automatic int slot_index(input int pos, input int num_pack, input bit big_endian);
        return big_endian ? (num_pack - 1 - pos) : pos;
    endfunction

endpackage

// File: rtl/axistream_pack_outreg.sv
// Output holding register for the packer: wide data plus a side field
// (last, and keep when enabled), loaded on a completing beat, drained by dest_tready.
module axistream_pack_outreg #(
    parameter int DATA_W = 32,
    parameter int SIDE_W = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [DATA_W-1:0] load_data,
    input  logic [SIDE_W-1:0] load_side,
    input  logic              dest_tready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic [SIDE_W-1:0] out_side
);

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_side  <= '0;
        end else if (load) begin
            // A load in the same cycle as a drain replaces the word being consumed.
            out_valid <= 1'b1;
            out_data  <= load_data;
            out_side  <= load_side;
        end else if (out_valid && dest_tready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/axistream_pack.sv
// Packs NUM_PACK narrow AXI-Stream words into one wide word; short packets are
// flushed zero-filled. Define AXISTREAM_PACK_TKEEP_EN to add the dest_tkeep port.
module axistream_pack
    import axistream_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_PACK   = 4,
    parameter bit BIG_ENDIAN = 1'b0
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           src_tvalid,
    output logic                           src_tready,
    input  logic [DATA_WIDTH-1:0]          src_tdata,
    input  logic                           src_tlast,
    output logic                           dest_tvalid,
    input  logic                           dest_tready,
    output logic [DATA_WIDTH*NUM_PACK-1:0] dest_tdata,
    output logic                           dest_tlast
`ifdef AXISTREAM_PACK_TKEEP_EN
    ,
    output logic [NUM_PACK-1:0]            dest_tkeep
`endif
);

    localparam int CW = cnt_width(NUM_PACK);
    localparam int WW = DATA_WIDTH * NUM_PACK;
`ifdef AXISTREAM_PACK_TKEEP_EN
    localparam int SIDE_W = NUM_PACK + 1;
`else
    localparam int SIDE_W = 1;
`endif

    logic [CW-1:0]       cnt;
    logic [WW-1:0]       acc;
    logic [WW-1:0]       acc_nxt;
    logic [WW-1:0]       merged;
    logic [NUM_PACK-1:0] hit;
    logic [NUM_PACK-1:0] written;
    logic [SIDE_W-1:0]   load_side;
    logic [SIDE_W-1:0]   out_side;
    logic                completing;
    logic                accept;
    logic                load;
    logic                out_valid;

    assign completing  = src_tvalid && ((cnt == CW'(NUM_PACK - 1)) || src_tlast);
    assign src_tready  = !rst && (!completing || !out_valid || dest_tready);
    assign accept      = src_tvalid && src_tready;
    assign load        = accept && completing;
    assign dest_tvalid = out_valid && !rst;

    for (genvar i = 0; i < NUM_PACK; i++) begin : g_slot
        localparam int POS = slot_index(i, NUM_PACK, BIG_ENDIAN);

        assign hit[i] = (cnt == CW'(POS));
        // Slots not yet written in this word are forced to zero, so stale acc never leaks.
        assign merged[i*DATA_WIDTH +: DATA_WIDTH] =
            hit[i]     ? src_tdata :
            written[i] ? acc[i*DATA_WIDTH +: DATA_WIDTH] : '0;
        assign acc_nxt[i*DATA_WIDTH +: DATA_WIDTH] =
            completing ? '0 :
            hit[i]     ? src_tdata : acc[i*DATA_WIDTH +: DATA_WIDTH];
`ifndef AXISTREAM_PACK_TKEEP_EN
        assign written[i] = (CW'(POS) < cnt);
`endif
    end

`ifdef AXISTREAM_PACK_TKEEP_EN
    logic [NUM_PACK-1:0] keep;

    always_ff @(posedge clk) begin
        if (rst) begin
            keep <= '0;
        end else if (accept) begin
            keep <= completing ? '0 : (keep | hit);
        end
    end

    assign written   = keep;
    assign load_side = {keep | hit, src_tlast};
    assign {dest_tkeep, dest_tlast} = out_side;
`else
    assign load_side  = src_tlast;
    assign dest_tlast = out_side[0];
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (accept) begin
            cnt <= completing ? '0 : cnt + CW'(1);
        end
    end

    // acc needs no reset: the written mask gates every read of it.
    always_ff @(posedge clk) begin
        if (accept) begin
            acc <= acc_nxt;
        end
    end

    axistream_pack_outreg #(
        .DATA_W (WW),
        .SIDE_W (SIDE_W)
    ) u_outreg (
        .clk         (clk),
        .rst         (rst),
        .load        (load),
        .load_data   (merged),
        .load_side   (load_side),
        .dest_tready (dest_tready),
        .out_valid   (out_valid),
        .out_data    (dest_tdata),
        .out_side    (out_side)
    );

endmodule

// File: tb/tb_axistream_pack.sv
// Bench for axistream_pack (8-bit words, 4 per wide word), little- and
// big-endian instances driven in parallel and checked against a packet model.
module tb_axistream_pack;

    localparam int NP = 4;

    logic        clk;
    logic        rst;
    logic        src_tvalid;
    logic [7:0]  src_tdata;
    logic        src_tlast;
    logic        dest_tready;
    logic        le_src_tready, be_src_tready;
    logic        le_dvalid, be_dvalid;
    logic [31:0] le_data, be_data;
    logic        le_last, be_last;
    logic [3:0]  le_keep, be_keep;

    typedef struct {
        logic [31:0] le;
        logic [31:0] be;
        logic        last;
        logic [3:0]  kle;
        logic [3:0]  kbe;
        int          cyc;
    } beat_t;

    typedef struct {
        logic [31:0] w;
        int          len;
        logic        last;
        logic [31:0] exp_le;
        logic [31:0] exp_be;
        logic [3:0]  keep_le;
        logic [3:0]  keep_be;
    } vec_t;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          last_acc_cyc = 0;
    logic [7:0]  pkt[$];
    beat_t       outq[$];
    beat_t       cap_q[$];
    vec_t        tbl[6];

    axistream_pack #(.DATA_WIDTH(8), .NUM_PACK(NP), .BIG_ENDIAN(1'b0)) dut_le (
        .clk         (clk),
        .rst         (rst),
        .src_tvalid  (src_tvalid),
        .src_tready  (le_src_tready),
        .src_tdata   (src_tdata),
        .src_tlast   (src_tlast),
        .dest_tvalid (le_dvalid),
        .dest_tready (dest_tready),
        .dest_tdata  (le_data),
        .dest_tlast  (le_last)
`ifdef AXISTREAM_PACK_TKEEP_EN
        ,
        .dest_tkeep  (le_keep)
`endif
    );

    axistream_pack #(.DATA_WIDTH(8), .NUM_PACK(NP), .BIG_ENDIAN(1'b1)) dut_be (
        .clk         (clk),
        .rst         (rst),
        .src_tvalid  (src_tvalid),
        .src_tready  (be_src_tready),
        .src_tdata   (src_tdata),
        .src_tlast   (src_tlast),
        .dest_tvalid (be_dvalid),
        .dest_tready (dest_tready),
        .dest_tdata  (be_data),
        .dest_tlast  (be_last)
`ifdef AXISTREAM_PACK_TKEEP_EN
        ,
        .dest_tkeep  (be_keep)
`endif
    );

`ifndef AXISTREAM_PACK_TKEEP_EN
    assign le_keep = 4'b0;
    assign be_keep = 4'b0;
`endif

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: collect the words of the current wide word, build the
    // expected wide word arithmetically, and track what dest must present.
    logic  prev_stall = 1'b0;
    logic [31:0] prev_le, prev_be;
    logic  prev_last;

    always @(negedge clk) begin
        logic  compl, exp_ready;
        beat_t e, c;
        compl     = src_tvalid && (pkt.size() == NP - 1 || src_tlast);
        exp_ready = !rst && !(compl && outq.size() > 0 && !dest_tready);
        check("src_tready_le", le_src_tready, exp_ready);
        check("src_tready_be", be_src_tready, exp_ready);
        check("dest_tvalid_le", le_dvalid, !rst && outq.size() > 0);
        check("dest_tvalid_be", be_dvalid, !rst && outq.size() > 0);
        if (!rst && prev_stall) begin
            check("hold_data_le", le_data, prev_le);
            check("hold_data_be", be_data, prev_be);
            check("hold_last", le_last, prev_last);
        end
        prev_stall = le_dvalid && !dest_tready;
        prev_le    = le_data;
        prev_be    = be_data;
        prev_last  = le_last;
        if (rst) begin
            pkt.delete();
            outq.delete();
        end else begin
            if (le_dvalid && dest_tready && outq.size() > 0) begin
                e = outq.pop_front();
                check("model_data_le", le_data, e.le);
                check("model_data_be", be_data, e.be);
                check("model_last_le", le_last, e.last);
                check("model_last_be", be_last, e.last);
`ifdef AXISTREAM_PACK_TKEEP_EN
                check("model_keep_le", le_keep, e.kle);
                check("model_keep_be", be_keep, e.kbe);
`endif
                c.le = le_data; c.be = be_data; c.last = le_last;
                c.kle = le_keep; c.kbe = be_keep; c.cyc = cyc;
                cap_q.push_back(c);
            end
            if (src_tvalid && exp_ready) begin
                pkt.push_back(src_tdata);
                if (compl) begin
                    e.le = '0; e.be = '0; e.kle = '0; e.kbe = '0;
                    e.last = src_tlast; e.cyc = 0;
                    for (int k = 0; k < pkt.size(); k++) begin
                        e.le[8*k +: 8]        = pkt[k];
                        e.be[8*(NP-1-k) +: 8] = pkt[k];
                        e.kle[k]              = 1'b1;
                        e.kbe[NP-1-k]         = 1'b1;
                    end
                    outq.push_back(e);
                    pkt.delete();
                end
            end
        end
    end

    // Entered and left at posedge+1.
    task automatic send_word(input logic [7:0] w, input logic last);
        bit done = 1'b0;
        src_tvalid = 1'b1;
        src_tdata  = w;
        src_tlast  = last;
        for (int t = 0; t < 100 && !done; t++) begin
            @(negedge clk);
            if (le_src_tready) begin
                done = 1'b1;
                last_acc_cyc = cyc;
            end
            @(posedge clk);
            #1;
        end
        src_tvalid = 1'b0;
        src_tlast  = 1'b0;
        check("send_accepted", done, 1'b1);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        beat_t c;
        int    idx;

        tbl[0] = '{32'h44332211, 4, 1'b1, 32'h44332211, 32'h11223344, 4'b1111, 4'b1111};
        tbl[1] = '{32'h0000BBAA, 2, 1'b1, 32'h0000BBAA, 32'hAABB0000, 4'b0011, 4'b1100};
        tbl[2] = '{32'hFFEEDDCC, 4, 1'b1, 32'hFFEEDDCC, 32'hCCDDEEFF, 4'b1111, 4'b1111};
        tbl[3] = '{32'h40302010, 4, 1'b0, 32'h40302010, 32'h10203040, 4'b1111, 4'b1111};
        tbl[4] = '{32'h0000005A, 1, 1'b1, 32'h0000005A, 32'h5A000000, 4'b0001, 4'b1000};
        tbl[5] = '{32'h00030201, 3, 1'b1, 32'h00030201, 32'h01020300, 4'b0111, 4'b1110};

        rst = 1'b1; src_tvalid = 1'b0; src_tdata = '0; src_tlast = 1'b0; dest_tready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("reset_data_le", le_data, 32'h0);
        check("reset_data_be", be_data, 32'h0);
        check("reset_last", le_last, 1'b0);
`ifdef AXISTREAM_PACK_TKEEP_EN
        check("reset_keep", le_keep, 4'b0);
`endif
        @(posedge clk);
        #1;

        for (int i = 0; i < 6; i++) begin
            cap_q.delete();
            for (int k = 0; k < tbl[i].len; k++)
                send_word(tbl[i].w[8*k +: 8], tbl[i].last && (k == tbl[i].len - 1));
            idle(3);
            check("tbl_count", cap_q.size(), 1);
            if (cap_q.size() > 0) begin
                c = cap_q.pop_front();
                check("tbl_data_le", c.le, tbl[i].exp_le);
                check("tbl_data_be", c.be, tbl[i].exp_be);
                check("tbl_last", c.last, tbl[i].last);
`ifdef AXISTREAM_PACK_TKEEP_EN
                check("tbl_keep_le", c.kle, tbl[i].keep_le);
                check("tbl_keep_be", c.kbe, tbl[i].keep_be);
`endif
                if (i == 0) check("latency", c.cyc - last_acc_cyc, 1);
            end
        end

        // Backpressure: 8 words offered while dest is stalled for 12 cycles.
        cap_q.delete();
        dest_tready = 1'b0;
        idx = 0;
        src_tvalid = 1'b1; src_tdata = 8'h81; src_tlast = 1'b0;
        for (int t = 0; t < 12; t++) begin
            @(negedge clk);
            if (le_src_tready) idx++;
            if (t == 11) check("bp_word8_stalled", le_src_tready, 1'b0);
            @(posedge clk);
            #1;
            if (idx < 8) begin
                src_tdata = 8'(8'h81 + idx);
                src_tlast = (idx == 7);
            end else begin
                src_tvalid = 1'b0;
            end
        end
        check("bp_accepted", idx, 7);
        dest_tready = 1'b1;
        for (int t = 0; t < 50 && idx < 8; t++) begin
            @(negedge clk);
            if (le_src_tready) idx++;
            @(posedge clk);
            #1;
            if (idx >= 8) src_tvalid = 1'b0;
        end
        src_tvalid = 1'b0; src_tlast = 1'b0;
        check("bp_all_accepted", idx, 8);
        idle(4);
        check("bp_count", cap_q.size(), 2);
        if (cap_q.size() == 2) begin
            check("bp_w0_le", cap_q[0].le, 32'h84838281);
            check("bp_w0_be", cap_q[0].be, 32'h81828384);
            check("bp_w0_last", cap_q[0].last, 1'b0);
            check("bp_w1_le", cap_q[1].le, 32'h88878685);
            check("bp_w1_be", cap_q[1].be, 32'h85868788);
            check("bp_w1_last", cap_q[1].last, 1'b1);
        end

        // Reset in the middle of a packet.
        cap_q.delete();
        send_word(8'h77, 1'b0);
        send_word(8'h66, 1'b0);
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        for (int k = 1; k <= 4; k++) send_word(8'(k), k == 4);
        idle(3);
        check("rst_count", cap_q.size(), 1);
        if (cap_q.size() > 0) begin
            check("rst_data_le", cap_q[0].le, 32'h04030201);
            check("rst_data_be", cap_q[0].be, 32'h01020304);
        end

        // Full-rate streaming.
        cap_q.delete();
        src_tvalid = 1'b1;
        for (int i = 0; i < 40; i++) begin
            src_tdata = 8'(i + 1);
            src_tlast = (i == 39);
            @(negedge clk);
            check("tp_ready", le_src_tready, 1'b1);
            @(posedge clk);
            #1;
        end
        src_tvalid = 1'b0; src_tlast = 1'b0;
        idle(3);
        check("tp_count", cap_q.size(), 10);
        for (int j = 1; j < cap_q.size(); j++)
            check("tp_spacing", cap_q[j].cyc - cap_q[j-1].cyc, 4);

        // Random traffic against the model, with occasional resets.
        for (int t = 0; t < 2000; t++) begin
            src_tvalid  = ($urandom % 4) != 0;
            src_tdata   = 8'($urandom);
            src_tlast   = ($urandom % 5) == 0;
            dest_tready = ($urandom % 3) != 0;
            rst         = ($urandom % 200) == 0;
            @(posedge clk);
            #1;
        end
        src_tvalid = 1'b0; src_tlast = 1'b0; rst = 1'b0; dest_tready = 1'b1;
        idle(5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
